fft_stage_seq: RTL and testbench
================================

# fft_stage_seq

Sequencer for the 4-input butterfly PE in the FFT datapath: walks all stages of an N-point transform, issuing one 4-sample bundle per cycle from the in-place sample memory. Generates the time-aligned twiddle ROM address, `bypass_n` and write-back controls for the PE's fixed 3-cycle pipeline. Sits between the top-level FFT controller (start/done) and the sample memory / twiddle ROM / PE.

## Interface
- `LOG2N`, 6: log2 of transform size N; minimum 3.
- `RD_LAT`, 1: sample-memory read latency, in cycles.
- `PE_LAT`, 3: PE input-to-output latency, in cycles.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `hold`  in  1  pause issue; in-flight bundles continue.
- `busy`  out  1  high from first issue cycle through last write-back.
- `done`  out  1  one-cycle pulse after the final write-back.
- `rd_en`  out  1  bundle read strobe.
- `rd_addr`  out  LOG2N-2  bundle index g, 0..N/4-1.
- `stage`  out  clog2(LOG2N)  current stage s, 0..LOG2N-1.
- `tf_addr`  out  LOG2N-1  twiddle ROM address; 1-cycle ROM latency.
- `bypass_n`  out  1  to PE; 0 selects the unmultiplied path.
- `wr_en`  out  1  write-back strobe for PE outputs.
- `wr_addr`  out  LOG2N-2  write-back bundle index; equal to the issuing `rd_addr`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 → ISSUE, with g=0 and s=0. `start` in any other state is ignored.
- ISSUE: each cycle with `hold`=0, assert `rd_en` with `rd_addr`=g, then increment g.
  - After issuing g=N/4-1, go to DRAIN.
  - With `hold`=1: `rd_en`=0, and g and s freeze.
- DRAIN: stay until the stage's last `wr_en` has fired.
  - Then, if s<LOG2N-1: s++, g=0, go to ISSUE.
  - Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Twiddle index: `tf_addr` = (g << s) mod N/2, computed at LOG2N-1 bits with overflow bits discarded.
- `bypass_n` = (twiddle index != 0).
- Issue metadata (valid, g, twiddle index, bypass) travels in a shift register that advances every cycle, regardless of `hold` or state.
- Reset mid-operation:
  - All state and the delay line clear to 0.
  - In-flight write-backs are dropped; no `wr_en` is emitted after reset.
  - FSM returns to IDLE.

## Timing
- Reset values: all outputs 0, including `bypass_n`=0 and `stage`=0.
- For an issue at cycle t, with L = RD_LAT+PE_LAT (4 by default):
  - `rd_en`/`rd_addr` valid at t.
  - `tf_addr` valid at t+RD_LAT.
  - `bypass_n` valid at t+RD_LAT+PE_LAT-1.
  - `wr_en`/`wr_addr` valid at t+L.
- `start` high at cycle c → first `rd_en` at c+1.
- Stage boundary: the last issue of a stage at cycle t is followed by the next stage's first issue at t+L+1. This keeps the in-place memory read-after-write safe.
- `busy` is high from the first `rd_en` through the final `wr_en` inclusive. `done` fires the cycle after the final `wr_en`.
- With no `hold`, total span per transform = LOG2N·(N/4 + L) cycles.
- `hold` during DRAIN has no effect.
- `hold` on the cycle of the last issue delays that issue and DRAIN entry one-for-one.

## Configuration
- `FFT_SEQ_BYPASS_EN` defined: `bypass_n` = (twiddle index != 0), so trivial unity-twiddle multiplies skip the multiplier path.
- Not defined: `bypass_n` is driven to 1 for every issued bundle (always multiply); its reset value stays 0.
- Addressing and timing are identical in both builds.

## Test plan
- LOG2N=4, `start` pulse at cycle 0, no `hold`:
  - `rd_en` at cycles 1–4, 9–12, 17–20, 25–28; `wr_en` at 5–8, 13–16, 21–24, 29–32.
  - `busy` high 1–32; `done` at 33.
- Twiddle check (LOG2N=4):
  - s=1, g=3 → `tf_addr`=6, `bypass_n`=1.
  - s=3, g=1 → `tf_addr`=0, `bypass_n`=0.
  - s=0, g=0 → `bypass_n`=0, driven 2 cycles after its `tf_addr`.
- `hold` high for 3 cycles at the second issue of stage 0:
  - `rd_en` at 1, then 5–7.
  - `wr_en` at 5, 9–11.
  - Stage 1 first issue at 12.
- `Reset_n` low at cycle 10 of a run:
  - All outputs 0 at cycle 11.
  - No `wr_en` afterwards.
  - A new `start` restarts at s=0, g=0.
- `start` reasserted while `busy`: ignored, and the issue sequence is unchanged.
- `FFT_SEQ_BYPASS_EN` undefined: every `wr_en`-associated `bypass_n` is 1, including the g=0 bundles.

Source files
------------

// File: rtl/fft_stage_seq.sv
// Stage/bundle sequencer for the 4-input butterfly PE: issues one bundle per cycle, drains between stages.
// Latency: rd at issue t, tf_addr at t+RD_LAT, bypass_n at t+RD_LAT+PE_LAT-1, wr at t+RD_LAT+PE_LAT.
// Backpressure: hold pauses issue only; in-flight bundles keep moving. FFT_SEQ_BYPASS_EN enables unity-twiddle bypass.
module fft_stage_seq #(
   parameter int LOG2N  = 6,
   parameter int RD_LAT = 1,
   parameter int PE_LAT = 3
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     start,
   input  logic                     hold,
   output logic                     busy,
   output logic                     done,
   output logic                     rd_en,
   output logic [LOG2N-3:0]         rd_addr,
   output logic [$clog2(LOG2N)-1:0] stage,
   output logic [LOG2N-2:0]         tf_addr,
   output logic                     bypass_n,
   output logic                     wr_en,
   output logic [LOG2N-3:0]         wr_addr
);
   localparam int GW     = LOG2N - 2;
   localparam int SW     = $clog2(LOG2N);
   localparam int TW     = LOG2N - 1;
   localparam int L      = RD_LAT + PE_LAT;
   localparam int BP_IDX = RD_LAT + PE_LAT - 1;
   localparam logic [GW-1:0] G_LAST = '1;
   localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   typedef struct packed {
      logic          vld;
      logic [GW-1:0] g;
   } meta_t;

   state_t        state, state_nxt;
   logic [GW-1:0] g;
   logic [SW-1:0] s;
   logic [TW-1:0] tw_idx;
   logic          issue_vld;
   logic          issue_bp;
   logic          last_wr;
   meta_t         pipe    [1:L];
   logic [TW-1:0] tw_pipe [1:RD_LAT];
   logic          bp_pipe [1:BP_IDX];

   always_ff @(posedge Clk) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // DRAIN exits on the write-back of the stage's final bundle, giving the t+L+1 restart.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   if (!hold && g == G_LAST) state_nxt = DRAIN;
         DRAIN:   if (last_wr) state_nxt = (s == S_LAST) ? DONE : ISSUE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == ISSUE) || (state == DRAIN);
      done      = (state == DONE);
      issue_vld = (state == ISSUE) && !hold;
      rd_en     = issue_vld;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         g <= '0;
         s <= '0;
      end else begin
         if (state == IDLE && start) begin
            g <= '0;
            s <= '0;
         end
         if (issue_vld) g <= g + 1'b1;
         if (state == DRAIN && last_wr && s != S_LAST) s <= s + 1'b1;
      end
   end

   // Shifting at TW bits discards the bits above N/2, i.e. the mod N/2 wrap.
   assign tw_idx = {1'b0, g} << s;

`ifdef FFT_SEQ_BYPASS_EN
   assign issue_bp = issue_vld && (tw_idx != '0);
`else
   assign issue_bp = issue_vld;
`endif

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int k = 1; k <= L; k++)      pipe[k]    <= '0;
         for (int k = 1; k <= RD_LAT; k++) tw_pipe[k] <= '0;
         for (int k = 1; k <= BP_IDX; k++) bp_pipe[k] <= 1'b0;
      end else begin
         pipe[1]    <= '{vld: issue_vld, g: g};
         tw_pipe[1] <= issue_vld ? tw_idx : '0;
         bp_pipe[1] <= issue_bp;
         for (int k = 2; k <= L; k++)      pipe[k]    <= pipe[k-1];
         for (int k = 2; k <= RD_LAT; k++) tw_pipe[k] <= tw_pipe[k-1];
         for (int k = 2; k <= BP_IDX; k++) bp_pipe[k] <= bp_pipe[k-1];
      end
   end

   always_comb begin
      rd_addr  = g;
      stage    = s;
      tf_addr  = tw_pipe[RD_LAT];
      bypass_n = bp_pipe[BP_IDX];
      wr_en    = pipe[L].vld;
      wr_addr  = pipe[L].g;
      last_wr  = pipe[L].vld && (pipe[L].g == G_LAST);
   end
endmodule

// File: tb/tb_fft_stage_seq.sv
// Bench for fft_stage_seq at LOG2N=4: vector table for a full run, plus hold and mid-run reset sequences.
module tb_fft_stage_seq;
   logic       Clk = 1'b0;
   logic       Reset_n, start, hold;
   logic       busy, done, rd_en, bypass_n, wr_en;
   logic [1:0] rd_addr, wr_addr, stage;
   logic [2:0] tf_addr;

`ifdef FFT_SEQ_BYPASS_EN
   localparam bit BP_EN = 1'b1;
`else
   localparam bit BP_EN = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   fft_stage_seq #(.LOG2N(4), .RD_LAT(1), .PE_LAT(3)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .start(start), .hold(hold),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
      .stage(stage), .tf_addr(tf_addr), .bypass_n(bypass_n),
      .wr_en(wr_en), .wr_addr(wr_addr)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       start;
      logic       rd;
      logic [1:0] ra;
      logic       wr;
      logic [1:0] wa;
      logic       busy;
      logic       done;
      logic       stg_v;
      logic [1:0] stg;
      logic       tf_v;
      logic [2:0] tf;
      logic       bp_v;
      logic       bp;
   } vec_t;

   localparam int NV = 36;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   // Leaves the bench #1 after the next rising edge, with cyc advanced.
   task automatic step();
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_bypass_n"}, bypass_n, 0);
      chk({tag, "_tf_addr"}, tf_addr, 0);
      chk({tag, "_stage"}, stage, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         step();
         @(negedge Clk);
         n++;
      end
      chk({tag, "_done_seen"}, done, 1);
      step();
   endtask

   initial begin
      // Expected timeline for LOG2N=4: stage k occupies cycles 8k+1..8k+8 (4 issues + 4 drain).
      for (int c = 0; c < NV; c++) begin
         int p, q, r;
         tbl[c] = '{start: 1'b0, rd: 1'b0, ra: 2'd0, wr: 1'b0, wa: 2'd0, busy: 1'b0, done: 1'b0,
                    stg_v: 1'b0, stg: 2'd0, tf_v: 1'b0, tf: 3'd0, bp_v: 1'b0, bp: 1'b0};
         if (c >= 1 && c <= 32) begin
            p = (c - 1) % 8;
            tbl[c].busy  = 1'b1;
            tbl[c].stg_v = 1'b1;
            tbl[c].stg   = 2'((c - 1) / 8);
            tbl[c].rd    = (p < 4);
            tbl[c].ra    = 2'(p);
         end
         if (c >= 2 && c <= 33 && (c - 2) % 8 < 4) begin
            q = (c - 2) % 8;
            tbl[c].tf_v = 1'b1;
            tbl[c].tf   = 3'((q << ((c - 2) / 8)) % 8);
         end
         if (c >= 4 && c <= 35 && (c - 4) % 8 < 4) begin
            r = ((c - 4) % 8) << ((c - 4) / 8);
            tbl[c].bp_v = 1'b1;
            tbl[c].bp   = BP_EN ? ((r % 8) != 0) : 1'b1;
         end
         if (c >= 5 && c <= 32 && (c - 5) % 8 < 4) begin
            tbl[c].wr = 1'b1;
            tbl[c].wa = 2'((c - 5) % 8);
         end
         tbl[c].done = (c == 33);
      end
      tbl[0].start  = 1'b1;
      tbl[10].start = 1'b1;
      tbl[14].start = 1'b1;

      Reset_n = 1'b0; start = 1'b0; hold = 1'b0;
      step(); step();
      @(negedge Clk);
      check_all_zero("reset");
      step();
      Reset_n = 1'b1;
      step();

      // Full run, with start re-pulsed mid-ISSUE and mid-DRAIN.
      cyc = 0;
      for (int c = 0; c < NV; c++) begin
         start = tbl[c].start;
         @(negedge Clk);
         chk("run_rd_en", rd_en, tbl[c].rd);
         if (tbl[c].rd) chk("run_rd_addr", rd_addr, tbl[c].ra);
         chk("run_wr_en", wr_en, tbl[c].wr);
         if (tbl[c].wr) chk("run_wr_addr", wr_addr, tbl[c].wa);
         chk("run_busy", busy, tbl[c].busy);
         chk("run_done", done, tbl[c].done);
         if (tbl[c].stg_v) chk("run_stage", stage, tbl[c].stg);
         if (tbl[c].tf_v) chk("run_tf_addr", tf_addr, tbl[c].tf);
         if (tbl[c].bp_v) chk("run_bypass_n", bypass_n, tbl[c].bp);
         step();
      end
      start = 1'b0;
      step();

      // Hold for 3 cycles at the second issue of stage 0.
      cyc = 0;
      start = 1'b1;
      for (int c = 0; c <= 12; c++) begin
         logic exp_rd, exp_wr;
         logic [1:0] exp_ra, exp_wa;
         exp_rd = (c == 1) || (c >= 5 && c <= 7) || (c == 12);
         exp_ra = (c == 1 || c == 12) ? 2'd0 : 2'(c - 4);
         exp_wr = (c == 5) || (c >= 9 && c <= 11);
         exp_wa = (c == 5) ? 2'd0 : 2'(c - 8);
         hold = (c >= 2 && c <= 4);
         @(negedge Clk);
         chk("hold_rd_en", rd_en, exp_rd);
         if (exp_rd) chk("hold_rd_addr", rd_addr, exp_ra);
         chk("hold_wr_en", wr_en, exp_wr);
         if (exp_wr) chk("hold_wr_addr", wr_addr, exp_wa);
         if (c == 12) chk("hold_stage1_start", stage, 1);
         step();
         start = 1'b0;
      end
      hold = 1'b0;
      wait_done("hold", 200);

      // Reset at cycle 10 of a run, then restart.
      cyc = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      while (cyc < 10) step();
      @(negedge Clk);
      chk("rst_pre_rd_en", rd_en, 1);
      Reset_n = 1'b0;
      step();
      Reset_n = 1'b1;
      @(negedge Clk);
      check_all_zero("rst_c11");
      for (int c = 12; c <= 20; c++) begin
         step();
         @(negedge Clk);
         chk("rst_no_wr_en", wr_en, 0);
         chk("rst_idle_busy", busy, 0);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge Clk);
      chk("restart_rd_en", rd_en, 1);
      chk("restart_rd_addr", rd_addr, 0);
      chk("restart_stage", stage, 0);
      for (int c = 1; c < 32; c++) step();
      @(negedge Clk);
      chk("restart_last_wr", wr_en, 1);
      chk("restart_last_stage", stage, 3);
      step();
      @(negedge Clk);
      chk("restart_done", done, 1);
      chk("restart_busy_low", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
